// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared types and constants for the memory-mapped UART transmitter.
//   word_t           - 32-bit bus data word
//   uart_tx_state_t  - serializer states
//   UART_*           - register offsets (ram_addr[3:2]) and STATUS bit positions
//   uart_baud_clamp  - maps a written divider of 0 to 1
// Optional feature macro used by the block: UART_TX_PARITY_EN.
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Register offsets, decoded from ram_addr[3:2]
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    // STATUS bit positions
    localparam int UART_ST_FULL    = 0;
    localparam int UART_ST_EMPTY   = 1;
    localparam int UART_ST_BUSY    = 2;
    localparam int UART_ST_PARITY  = 3;
    localparam int UART_ST_CNT_LSB = 8;
    localparam int UART_ST_CNT_W   = 7;

    // A zero divider would never finish a bit; store it as 1 instead.
    function automatic logic [15:0] uart_baud_clamp(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU-to-memory request/response bundle.
//   ram_ren/ram_wen  - read/write request, held until ram_ready
//   ram_addr         - byte address
//   ram_store        - write data
//   ram_load         - read data, valid only with ram_ready
//   ram_ready        - one-cycle completion pulse
// Modports: master (CPU side), slave (responder side).
interface uart_tx_mmio_if;
    import rv32ima_pkg::*;

    logic  ram_ren;
    logic  ram_wen;
    word_t ram_addr;
    word_t ram_store;
    word_t ram_load;
    logic  ram_ready;

    modport master (
        output ram_ren, ram_wen, ram_addr, ram_store,
        input  ram_load, ram_ready
    );

    modport slave (
        input  ram_ren, ram_wen, ram_addr, ram_store,
        output ram_load, ram_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
//   clk, rst          - clock, synchronous active-high reset
//   push_i, din_i     - write strobe and data (ignored when full unless popping)
//   pop_i, dout_o     - read strobe and head-of-queue data (ignored when empty)
//   full_o, empty_o   - occupancy flags
//   count_o           - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the CPU request/response bus.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - uart_tx_mmio_if.slave (ram_ren/wen/addr/store in, ram_load/ready out)
//   tx        - serial output, idles high
// Registers (ram_addr[3:2]): 0 TXDATA (W push), 1 STATUS (R), 2 BAUDDIV (R/W), 3 reserved.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
    import rv32ima_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] BAUD_DIV_INIT = 16'd868
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_mmio_if.slave      bus,
    output logic               tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- FIFO
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (bus.ram_store[7:0]),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------------------------------------------------------- bus side
    logic           ready_q, ready_d;
    word_t          load_q, load_d;
    logic [15:0]    baud_q, baud_d;
    uart_tx_state_t state_q, state_d;

    logic       req, tx_wr, complete;
    logic [1:0] off;
    word_t      status_w;

    // The cycle carrying ram_ready still sees the held request; gating on
    // ready_q keeps that from being taken as a new access.
    assign req   = (bus.ram_ren || bus.ram_wen) && !ready_q;
    assign off   = bus.ram_addr[3:2];
    assign tx_wr = req && bus.ram_wen && (off == UART_TXDATA);

    // A TXDATA write into a full FIFO waits; it completes on the cycle a pop frees a slot.
    assign fifo_push = tx_wr && (!fifo_full || fifo_pop);
    assign complete  = req && (!tx_wr || fifo_push);

    always_comb begin
        status_w                                   = '0;
        status_w[UART_ST_FULL]                     = fifo_full;
        status_w[UART_ST_EMPTY]                    = fifo_empty;
        status_w[UART_ST_BUSY]                     = (state_q != IDLE);
        status_w[UART_ST_PARITY]                   = PAR_EN;
        status_w[UART_ST_CNT_LSB +: UART_ST_CNT_W] = UART_ST_CNT_W'(fifo_count);
    end

    always_comb begin
        ready_d = complete;
        load_d  = '0;
        baud_d  = baud_q;
        if (complete && bus.ram_ren) begin
            case (off)
                UART_STATUS:  load_d = status_w;
                UART_BAUDDIV: load_d = {16'd0, baud_q};
                default:      load_d = '0;
            endcase
        end
        if (complete && bus.ram_wen && (off == UART_BAUDDIV))
            baud_d = uart_baud_clamp(bus.ram_store[15:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            load_q  <= '0;
            baud_q  <= BAUD_DIV_INIT;
        end else begin
            ready_q <= ready_d;
            load_q  <= load_d;
            baud_q  <= baud_d;
        end
    end

    assign bus.ram_ready = ready_q;
    assign bus.ram_load  = load_q;

    // ---------------------------------------------------------------- serializer
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        bit_end;
    logic [15:0] cnt_reload;

    assign bit_end    = (cnt_q == 16'd0);
    // baud_q is sampled only here, so a BAUDDIV write lands at the next bit start.
    assign cnt_reload = baud_q - 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? cnt_reload : cnt_q - 16'd1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!fifo_empty) begin
                    state_d  = START;
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    cnt_d    = cnt_reload;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Back-to-back frames: go straight to START with no idle bit.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        state_d  = START;
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // shreg_q is held for the whole frame; data bits are indexed rather than shifted.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shreg_q[bit_q];
            PARITY:  tx = ^shreg_q;
            default: tx = 1'b1;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{bus.ram_addr[31:4], bus.ram_addr[1:0], bus.ram_store[31:16]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with a frame-level tx model.
// Bytes completed on the bus queue into the model, which emits frames of NB bits
// (start, LSB-first data, optional parity, stop) of cur_baud cycles each, back to back.
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PB = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(.FIFO_DEPTH(8), .BAUD_DIV_INIT(16'd868)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [7:0] mdl_in[$];
    logic [7:0] mq[$];
    int         cur_baud = 868;
    logic       mbusy = 1'b0;
    int         mk, mbaud;
    logic [10:0] mframe;
    logic       prev_rdy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                mdl_in.delete();
                mbusy    = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                logic exp_tx;
                exp_tx = 1'b1;
                if (mbusy) begin
                    exp_tx = mframe[mk / mbaud];
                    mk++;
                    if (mk == NB * mbaud) mbusy = 1'b0;
                end
                chk("tx", tx, exp_tx);
                if (!bus.ram_ready) chk("load_idle", bus.ram_load, 0);
                chk("ready_pulse", bus.ram_ready && prev_rdy, 0);
                prev_rdy = bus.ram_ready;
                while (mdl_in.size() > 0) mq.push_back(mdl_in.pop_front());
                if (!mbusy && mq.size() > 0) begin
                    logic [7:0] b;
                    b         = mq.pop_front();
                    mframe    = '1;
                    mframe[0] = 1'b0;
                    mframe[8:1] = b;
                    if (NB == 11) mframe[9] = ^b;
                    mk    = 0;
                    mbaud = cur_baud;
                    mbusy = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ bus driver
    // Called at a negedge; returns at the negedge where ram_ready is seen.
    task automatic acc(input logic we, input logic [1:0] off, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.ram_ren   = !we;
        bus.ram_wen   = we;
        bus.ram_addr  = {28'h0, off, 2'b00};
        bus.ram_store = wd;
        lat = 0;
        rd  = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.ram_ready && lat < 100);
        if (!bus.ram_ready) chk("bus_timeout", 64'(lat), 0);
        rd = bus.ram_load;
        if (bus.ram_ready && we && off == 2'd0) mdl_in.push_back(wd[7:0]);
        if (bus.ram_ready && we && off == 2'd2) cur_baud = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
        bus.ram_ren = 1'b0;
        bus.ram_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        cur_baud = 868;
    endtask

    logic [31:0] rd;
    int          lat;
    logic [43:0] cap;

    initial begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        repeat (3) @(negedge clk);
        do_reset();
        chk("rst_tx", tx, 1);

        acc(0, 2'd1, 0, rd, lat);
        chk("status_lat", lat, 1);
        chk("status_rst", rd, 32'h2 | PB);
        acc(0, 2'd2, 0, rd, lat);
        chk("baud_rst", rd, 868);

        acc(1, 2'd2, 4, rd, lat);
        chk("baud_wr_lat", lat, 1);
        acc(0, 2'd2, 0, rd, lat);
        chk("baud_4", rd, 4);

        // 0x55 at divider 4: alternating bits, 4 cycles each
        acc(1, 2'd0, 32'h55, rd, lat);
        chk("tx55_lat", lat, 1);
        chk("tx55_pre", tx, 1);
        cap = '0;
        for (int i = 0; i < NB * 4; i++) begin
            @(negedge clk);
            cap = {cap[42:0], tx};
        end
        chk("tx55_wave", cap, (NB == 11) ? 44'h0F0F0F0F00F : 44'h0F0F0F0F0F);

        acc(1, 2'd2, 0, rd, lat);
        acc(0, 2'd2, 0, rd, lat);
        chk("baud_0_as_1", rd, 1);
        acc(0, 2'd0, 0, rd, lat);
        chk("txdata_rd", rd, 0);
        acc(1, 2'd3, 32'hFFFF_FFFF, rd, lat);
        acc(0, 2'd3, 0, rd, lat);
        chk("reg3_rd", rd, 0);
        acc(1, 2'd1, 32'hFFFF_FFFF, rd, lat);
        acc(0, 2'd1, 0, rd, lat);
        chk("status_ro", rd, 32'h2 | PB);

        // Burst at divider 2: 9 writes fill the FIFO (first byte already popped),
        // the 10th stalls until the first frame ends.
        acc(1, 2'd2, 2, rd, lat);
        for (int i = 0; i < 9; i++) begin
            acc(1, 2'd0, 32'hA0 + i, rd, lat);
            chk("burst_lat", lat, 1);
        end
        acc(0, 2'd1, 0, rd, lat);
        chk("status_full", rd, 32'h805 | PB);
        acc(1, 2'd0, 32'hA9, rd, lat);
        chk("full_wait_lat", lat, (NB == 11) ? 4 : 2);
        repeat (10 * NB * 2 + 20) @(negedge clk);
        acc(0, 2'd1, 0, rd, lat);
        chk("status_drained", rd, 32'h2 | PB);

        // 0x07 at divider 1
        acc(1, 2'd2, 1, rd, lat);
        acc(1, 2'd0, 32'h07, rd, lat);
        cap = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            cap = {cap[42:0], tx};
        end
        chk("tx07_wave", cap, 44'b01110000011);

        // Reset during data bit 3 of 0xC3 at divider 4
        repeat (5) @(negedge clk);
        acc(1, 2'd2, 4, rd, lat);
        acc(1, 2'd0, 32'hC3, rd, lat);
        repeat (18) @(negedge clk);
        chk("mid_bit3", tx, 0);
        do_reset();
        chk("post_rst_tx", tx, 1);
        acc(0, 2'd1, 0, rd, lat);
        chk("post_rst_status", rd, 32'h2 | PB);
        acc(0, 2'd2, 0, rd, lat);
        chk("post_rst_baud", rd, 868);
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
